// File: rtl/count_cmd_sched_if.sv
// Button/strobe bundle between the board buttons, the scheduler and the card counter.
// The scheduler takes the slave side; whoever drives the buttons takes the master side.
interface count_cmd_sched_if;
    logic        btn_large;
    logic        btn_seven;
    logic        btn_small;
    logic        btn_deck;
    logic        btn_back;
    logic        shoe_clear;
    logic        large_add;
    logic        seven_add;
    logic        small_add;
    logic        deck_add;
    logic        back;
    logic        phase;
    logic        busy;
    logic        rej;
    logic [15:0] cmd_count;

    modport master (
        output btn_large, btn_seven, btn_small, btn_deck, btn_back, shoe_clear,
        input  large_add, seven_add, small_add, deck_add, back, phase, busy, rej, cmd_count
    );

    modport slave (
        input  btn_large, btn_seven, btn_small, btn_deck, btn_back, shoe_clear,
        output large_add, seven_add, small_add, deck_add, back, phase, busy, rej, cmd_count
    );
endinterface

// File: rtl/count_cmd_sched.sv
// Card-counter command scheduler: synchronises, debounces and arbitrates five raw
// buttons and issues exactly one registered command strobe per clean press.
module count_cmd_sched #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic               clk,
    input  logic               rst,
    count_cmd_sched_if.slave   bus
);

    localparam int          NUM_KEYS  = 5;
    localparam int          KEY_DECK  = 3;
    localparam int          KEY_BACK  = 4;
    localparam logic [15:0] CNT_LAST  = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_ISSUE,
        ST_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]   key_q, key_d;
    logic                  phase_q, phase_d;
    logic [15:0]           cmd_count_q, cmd_count_d;
    logic [NUM_KEYS-1:0]   stb_q, stb_d;
    logic                  rej_q, rej_d;

    logic [NUM_KEYS-1:0]   btn_raw;
    logic [NUM_KEYS-1:0]   sync1_q, sync2_q;
    logic [NUM_KEYS-1:0]   s;
    logic                  key_illegal;

    // Bit order {back, deck, small, seven, large} is shared by keys and strobes.
    assign btn_raw = {bus.btn_back, bus.btn_deck, bus.btn_small, bus.btn_seven, bus.btn_large};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    // deck only makes sense while setting up the shoe, undo only once play has begun
    assign key_illegal = !$onehot(key_q)
                       || (key_q[KEY_DECK] &&  phase_q)
                       || (key_q[KEY_BACK] && !phase_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            phase_q     <= 1'b0;
            cmd_count_q <= '0;
            stb_q       <= '0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            phase_q     <= phase_d;
            cmd_count_q <= cmd_count_d;
            stb_q       <= stb_d;
            rej_q       <= rej_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        phase_d     = phase_q;
        cmd_count_d = cmd_count_q;
        stb_d       = '0;
        rej_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s != '0) begin
                    key_d   = s;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (s == '0) begin
                    state_d = ST_IDLE;
                end else if (s != key_q) begin
                    key_d = s;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ISSUE;
                    if (key_illegal) begin
                        rej_d = 1'b1;
                    end else begin
                        stb_d = key_q;
                        if (cmd_count_q != COUNT_MAX)
                            cmd_count_d = cmd_count_q + 16'd1;
                        if (|key_q[2:0])
                            phase_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_ISSUE: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end

            ST_RELEASE: begin
                // a key still (or newly) held restarts the all-released window
                if (s != '0)
                    cnt_d = '0;
                else if (cnt_q == CNT_LAST)
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q + 16'd1;
            end

            default: state_d = ST_IDLE;
        endcase

        // new shoe wins over whatever the FSM decided on this edge
        if (bus.shoe_clear) begin
            phase_d     = 1'b0;
            cmd_count_d = '0;
            state_d     = ST_RELEASE;
            cnt_d       = '0;
            stb_d       = '0;
            rej_d       = 1'b0;
        end
    end

    assign bus.large_add = stb_q[0];
    assign bus.seven_add = stb_q[1];
    assign bus.small_add = stb_q[2];
    assign bus.deck_add  = stb_q[KEY_DECK];
    assign bus.back      = stb_q[KEY_BACK];
    assign bus.rej       = rej_q;
    assign bus.phase     = phase_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.cmd_count = cmd_count_q;

endmodule
